mul_div_sequencer: RTL
======================

# mul_div_sequencer

Multi-cycle multiply/divide unit and its sequencer for the EX stage of the pipelined MIPS core. It accepts a decoded ALU control code for Mul (4'b0101) or Div (4'b1011) together with two 32-bit operands. It runs a 32-iteration signed shift-add multiply or restoring divide, and holds the pipeline through a Stall output until the result is written to its Hi/Lo registers. Single-cycle ALU operations bypass it: it never asserts Stall for them.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- ALU_Control  in  4  decoded operation from the ALU control decoder in EX.
- Start  in  1  EX holds a valid instruction this cycle.
- Flush  in  1  squash the in-flight operation (branch/jump redirect).
- A  in  32  rs operand: multiplicand or dividend.
- B  in  32  rt operand: multiplier or divisor.
- Stall  out  1  freeze IF/ID/EX; combinational.
- Done  out  1  one-cycle pulse; Hi/Lo were updated at this edge.
- Hi  out  32  product[63:32] or remainder.
- Lo  out  32  product[31:0] or quotient.

## Operation
- States: IDLE, BUSY, FIXUP, DONE.
- Accept condition: IDLE & Start & !Flush & ALU_Control ∈ {MUL, DIV}.
  - On accept, latch the operation, |A|, |B| and the result sign:
    - mul: sign = A[31]^B[31].
    - div: quotient sign = A[31]^B[31]; remainder sign = A[31].
  - Clear the working accumulator and set the iteration counter to 0.
- Divide by zero (DIV with B==0):
  - IDLE→DONE directly.
  - Lo=32'hFFFFFFFF, Hi=A.
- BUSY:
  - One iteration per cycle, counter 0..31.
  - Multiply: 64-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle.
  - After the iteration with counter==31, go to FIXUP.
- FIXUP:
  - Apply two's-complement negation per the latched signs.
  - Write Hi/Lo, go to DONE.
- DONE: Done=1 for one cycle, then go to IDLE.
- Arithmetic rules:
  - Magnitudes are 32-bit unsigned; |0x80000000| = 0x80000000.
  - Multiply yields the full 64-bit signed product.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - 0x80000000 / -1 gives Lo=0x80000000, Hi=0 (wraps, no trap).
- Start while not IDLE is ignored; ALU_Control changes in BUSY/FIXUP are ignored.
- Flush in BUSY or FIXUP:
  - Next state is IDLE.
  - Hi/Lo are not written and Done is not pulsed.
- Flush in DONE: no effect; the result is already committed.
- Flush has priority over accept.
- Hi/Lo hold their value until the next committed operation.

## Timing
- Cycle 0 = the cycle in which accept is true.
- Stall = accept | BUSY | FIXUP.
  - Normal operation: Stall is high in cycles 0–33, low in cycle 34.
  - Divide by zero: Stall is high in cycle 0 only.
- Normal operation:
  - BUSY in cycles 1–32, FIXUP in cycle 33.
  - Hi/Lo update at the end of cycle 33.
  - DONE with Done=1 in cycle 34.
- Divide by zero: Hi/Lo update at the end of cycle 0; Done=1 in cycle 1.
- Earliest back-to-back start: the cycle after DONE (cycle 35), since Stall is low in DONE and EX advances.
- Reset (async, any state):
  - State goes to IDLE.
  - Hi=0, Lo=0, Done=0, Stall=0.
  - Counter and working registers are cleared.
- Release of Reset_n takes effect at the first Clk edge after deassertion.

## Structure
- Package mul_div_pkg holds:
  - ALU_MUL=4'b0101, ALU_DIV=4'b1011.
  - The state encoding (IDLE, BUSY, FIXUP, DONE).
  - ITER=32.
- The control FSM and counter live in mul_div_sequencer.
- One sub-module, md_step: combinational single iteration taking op, accumulator and operand, returning the next accumulator. It is instantiated once.

## Test plan
- Mul A=7, B=-3 (0xFFFFFFFD): Stall 1 in cycles 0–33; Done in cycle 34; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Mul A=B=0x80000000: Hi=0x40000000, Lo=0x00000000.
- Div A=100, B=7 gives Lo=14, Hi=2. Div A=-100, B=7 gives Lo=0xFFFFFFF2, Hi=0xFFFFFFFE.
- Div A=5, B=0: Stall only in cycle 0, Done in cycle 1, Lo=0xFFFFFFFF, Hi=5.
- Flush and reset during a Mul:
  - Prior Hi/Lo = 0x1234/0x5678; start a Mul; assert Flush in cycle 10. Expect IDLE in cycle 11, Stall=0, no Done, Hi/Lo unchanged.
  - Repeat with Reset_n pulsed low in cycle 20 instead. Expect all outputs 0 immediately.
- Non-mul/div and ignored inputs:
  - Start with ALU_Control=4'b0010 (add): Stall=0, no state change.
  - Start re-asserted during BUSY: ignored; the result matches the first operation.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared constants, state encoding and latched-operand payload for the
// multi-cycle multiply/divide unit.
package mul_div_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    localparam logic [3:0] ALU_MUL = 4'b0101;
    localparam logic [3:0] ALU_DIV = 4'b1011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Operation captured at accept; magnitudes feed the unsigned iteration.
    typedef struct packed {
        logic             op_div;
        logic             neg_q;
        logic             neg_r;
        logic [WIDTH-1:0] mag_a;
        logic [WIDTH-1:0] mag_b;
    } md_latch_t;

    // |x| as an unsigned value; the most negative number maps to itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/md_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// Multiply: acc = {partial_hi, product bits shifted in from the top}.
// Divide:   acc = {remainder, quotient bits shifted in at the bottom}.
module md_step
    import mul_div_pkg::*;
(
    input  logic               op_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               bit_in,
    output logic [2*WIDTH-1:0] acc_nxt_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, operand} : '0);
        rem_sh    = {acc[2*WIDTH-1:WIDTH], bit_in};
        diff      = rem_sh - {1'b0, operand};
        acc_nxt_c = {sum, acc[WIDTH-1:1]};
        if (op_div) begin
            // Remainder stays below the divisor, so diff[WIDTH] is a clean borrow.
            if (!diff[WIDTH]) begin
                acc_nxt_c = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_c = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mul_div_sequencer.sv
// EX-stage multi-cycle signed multiply/divide with pipeline stall control
// and Hi/Lo result registers.
module mul_div_sequencer
    import mul_div_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [3:0]       ALU_Control,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    md_latch_t          lat;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step_c;
    logic               accept_c;
    logic               div_zero_c;
    logic [CNT_W-1:0]   bit_idx_c;
    logic               step_bit_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   quo_c;
    logic [WIDTH-1:0]   rem_c;

    // Accept/stall decode, iteration bit select and sign fixup.
    always_comb begin
        accept_c   = (state == IDLE) && Start && !Flush &&
                     ((ALU_Control == ALU_MUL) || (ALU_Control == ALU_DIV));
        div_zero_c = (ALU_Control == ALU_DIV) && (B == '0);
        Stall      = accept_c || (state == BUSY) || (state == FIXUP);
        // Divide walks the dividend MSB first; multiply walks the multiplier LSB first.
        bit_idx_c  = lat.op_div ? ~cnt : cnt;
        step_bit_c = lat.op_div ? lat.mag_a[bit_idx_c] : lat.mag_b[bit_idx_c];
        prod_c     = lat.neg_q ? (2*WIDTH)'(-acc) : acc;
        quo_c      = lat.neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_c      = lat.neg_r ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    md_step u_md_step (
        .op_div    (lat.op_div),
        .acc       (acc),
        .operand   (lat.op_div ? lat.mag_b : lat.mag_a),
        .bit_in    (step_bit_c),
        .acc_nxt_c (acc_step_c)
    );

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = div_zero_c ? DONE : BUSY;
            BUSY: begin
                if (Flush)                           state_nxt = IDLE;
                else if (cnt == CNT_W'(ITER - 1))    state_nxt = FIXUP;
            end
            FIXUP:   state_nxt = Flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Operand latch, iteration datapath and committed results.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt  <= '0;
            lat  <= '0;
            acc  <= '0;
            Hi   <= '0;
            Lo   <= '0;
            Done <= 1'b0;
        end else begin
            Done <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        lat.op_div <= (ALU_Control == ALU_DIV);
                        lat.neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                        lat.neg_r  <= A[WIDTH-1];
                        lat.mag_a  <= magnitude(A);
                        lat.mag_b  <= magnitude(B);
                        acc        <= '0;
                        cnt        <= '0;
                        if (div_zero_c) begin
                            Hi <= A;
                            Lo <= '1;
                        end
                    end
                end
                BUSY: begin
                    acc <= acc_step_c;
                    cnt <= CNT_W'(cnt + 1'b1);
                end
                FIXUP: begin
                    if (!Flush) begin
                        if (lat.op_div) begin
                            Hi <= rem_c;
                            Lo <= quo_c;
                        end else begin
                            Hi <= prod_c[2*WIDTH-1:WIDTH];
                            Lo <= prod_c[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
